fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch bus initiator for the rv32 core; drives the shared memory bus (addr/rw/size/data) as a read-only master toward the instruction ROM.
- Issues sequential word reads, captures the registered read data one cycle later and buffers fetched words in a small FIFO.
- Hands fetched words to the decode stage with a valid/ready handshake.
- Supports PC redirect (branch/jump) with flush of all in-flight and buffered fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bus_addr  out  32  bus address, registered.
- bus_rw  out  1  bus direction; 0 = read; held at 0.
- bus_size  out  2  00 none, 01 byte, 10 half, 11 word; only 00 or 11 driven; registered.
- bus_data  in  32  read data; valid in the cycle after a request cycle.
- bus_gnt  in  1  arbiter grant; a new request launches only while high.
- redirect_valid  in  1  load new PC, flush.
- redirect_pc  in  32  redirect target.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decode accepts head.
- inst_data  out  32  head instruction word.
- inst_pc  out  32  address of the head word.
- halted  out  1  fetch stopped (optional feature; constant 0 otherwise).

Behaviour:
- Reset (async, rst_n low): bus_addr=0, bus_size=00, bus_rw=0, FIFO empty, inst_valid=0, halted=0, next_pc=RESET_PC, both pipeline slots invalid.
- Request cycle R: bus_size=11, bus_addr=next_pc. ROM registers at the edge ending R; data is valid during the following cycle D; the unit writes {pc, bus_data} into the FIFO at the edge ending D. Latency: request launch to inst_valid = 2 edges.
- Launch condition (evaluated at each edge for the next cycle): bus_gnt & !halted & (fifo_count + inflight) < FIFO_DEPTH, with inflight = valid R slot + valid D slot. On launch, next_pc += 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Data-phase hold: the ROM output enable follows the current size. In any cycle D that has no new launch, the unit re-drives the previous bus_addr with bus_size=11. This read is a hold only and is never counted or captured. Otherwise bus_size=00.
- The arbiter does not revoke the bus in the cycle after a request.
- Back-to-back launches give 1 word/cycle sustained throughput.
- FIFO: push at the D-capture edge; pop on inst_valid & inst_ready. Simultaneous push and pop are allowed when full or empty. The credit rule guarantees no overflow; a push while full is a design error and must be asserted.
- Redirect (redirect_valid sampled high at an edge):
  - FIFO is cleared; R and D slots are invalidated, so the response still on the bus is dropped.
  - next_pc = {redirect_pc[31:2], 2'b00}.
  - A request for the target launches at the same edge if bus_gnt is high.
  - Redirect beats a simultaneous pop and a simultaneous capture.
  - Redirect clears halted.
- inst_data and inst_pc are stable while inst_valid=1 and inst_ready=0.
- Reset mid-operation: all state returns to reset values immediately; a pending bus response is ignored.

Optional Feature:
- Macro: FETCH_HALT_ON_EBREAK_EN.
- With the macro:
  - A captured word equal to 32'h0010_0073 (ebreak) is pushed normally.
  - At that same edge halted<=1 and all younger in-flight slots are invalidated.
  - No further launches occur until a redirect or reset.
  - Buffered words ahead of and including the ebreak still drain.
- Without the macro: halted is tied 0 and ebreak is fetched past like any other word.

Test Plan:
- Reset, RESET_PC=0, inst_ready=1, bus_gnt=1 -> bus_size=11 / bus_addr=0x0 in the first cycle after rst_n rises; inst_valid with inst_pc=0x0 and inst_data=ROM[0] two edges later; then pc 0x4, 0x8, ... one per cycle.
- inst_ready=0 for 10 cycles -> at most 4 entries; bus_size=00 after the last data phase; release -> PCs delivered in order with none lost or duplicated.
- redirect_pc=0x1E while R and D are both valid -> stale word discarded; next bus_addr=0x1C; first inst_pc=0x1C.
- redirect_pc=0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000.
- redirect_valid and an inst_ready pop in the same cycle, plus rst_n pulsed low mid-burst -> FIFO empty after each event; no stale inst_valid.
- ebreak at 0x3C, macro on -> inst_pc=0x3C delivered, halted=1, no request for 0x40; macro off -> fetch continues to 0x40.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-side bus (toward the instruction ROM) and the decode handshake, bundled for fetch_unit.
interface fetch_unit_if;
  logic [31:0] bus_addr;
  logic        bus_rw;
  logic [1:0]  bus_size;
  logic [31:0] bus_data;
  logic        bus_gnt;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  modport master (
    output bus_addr, bus_rw, bus_size, inst_valid, inst_data, inst_pc,
    input  bus_data, bus_gnt, inst_ready
  );

  modport slave (
    input  bus_addr, bus_rw, bus_size, inst_valid, inst_data, inst_pc,
    output bus_data, bus_gnt, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with a credit-limited R/D bus pipeline, an instruction FIFO and redirect flush.
// Optional: FETCH_HALT_ON_EBREAK_EN stops launching after a captured ebreak until redirect/reset.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         halted
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  fetch_entry_t  fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    vld_pipe;   // [0] request slot R, [1] data slot D
  logic [31:0]   pc_pipe [2];
  logic [31:0]   next_pc, launch_pc, addr_q;
  logic [1:0]    size_q;
  logic [AW+1:0] credit;
  logic          launch, hold_d, push, pop, full, ebreak_hit, halted_q;
  logic          unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

`ifdef FETCH_HALT_ON_EBREAK_EN
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  assign ebreak_hit = vld_pipe[1] && (bus.bus_data == EBREAK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              halted_q <= 1'b0;
    else if (redirect_valid) halted_q <= 1'b0;
    else if (ebreak_hit)     halted_q <= 1'b1;
  end
`else
  assign ebreak_hit = 1'b0;
  assign halted_q   = 1'b0;
`endif

  // Credit counts buffered words plus both in-flight slots so a capture never finds the FIFO full.
  assign credit    = (AW+2)'(count) + (AW+2)'(vld_pipe[0]) + (AW+2)'(vld_pipe[1]);
  assign launch_pc = redirect_valid ? {redirect_pc[31:2], 2'b00} : next_pc;
  assign launch    = bus.bus_gnt &
                     (redirect_valid | (!halted_q & !ebreak_hit & (credit < (AW+2)'(FIFO_DEPTH))));
  assign hold_d    = vld_pipe[0] & !redirect_valid & !ebreak_hit;
  assign push      = vld_pipe[1] & !redirect_valid;
  assign pop       = bus.inst_valid & bus.inst_ready & !redirect_valid;
  assign full      = (count == (AW+1)'(FIFO_DEPTH));

  // A D cycle without a fresh launch keeps size=11 on the old address so the ROM keeps driving data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      size_q     <= 2'b00;
      next_pc    <= RESET_PC;
      vld_pipe   <= '0;
      pc_pipe[0] <= '0;
      pc_pipe[1] <= '0;
    end else begin
      vld_pipe   <= {hold_d, launch};
      pc_pipe[1] <= pc_pipe[0];
      if (launch) begin
        addr_q     <= launch_pc;
        size_q     <= 2'b11;
        next_pc    <= launch_pc + 32'd4;
        pc_pipe[0] <= launch_pc;
      end else begin
        size_q     <= hold_d ? 2'b11 : 2'b00;
        next_pc    <= launch_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{pc: pc_pipe[1], word: bus.bus_data};
  end

  assign bus.bus_addr   = addr_q;
  assign bus.bus_size   = size_q;
  assign bus.bus_rw     = 1'b0;
  assign bus.inst_valid = (count != '0);
  assign bus.inst_data  = fifo_q[rd_ptr].word;
  assign bus.inst_pc    = fifo_q[rd_ptr].pc;
  assign halted         = halted_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random gnt/ready/redirect/reset against an in-order PC stream model.
module tb_fetch_unit;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic        rom_ebreak;
  logic [31:0] rom_q = '0;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_pc;
  logic        mdl_halted;
  logic [31:0] got_q [$];
  logic        prev_rst = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0, prev_redir = 1'b0;
  logic [31:0] prev_pc = '0, prev_data = '0;

  fetch_unit_if bus_if();

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] w;
    if (rom_ebreak && a == 32'h3C) return EBREAK;
    w = (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    if (w == EBREAK) w = w ^ 32'h1;
    return w;
  endfunction

  // Registered ROM: latches the word for any size=11 cycle, data visible the next cycle.
  assign bus_if.bus_data = rom_q;
  always @(posedge clk) if (bus_if.bus_size == 2'b11) rom_q <= rom_word(bus_if.bus_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: accepted words form the sequence start, start+4, ... from the last reset/redirect.
  task automatic monitor();
    if (!rst_n) begin
      exp_pc     = 32'h0;
      mdl_halted = 1'b0;
    end else begin
      chk("bus_rw", bus_if.bus_rw, 0);
      chk("size_legal", (bus_if.bus_size == 2'b00 || bus_if.bus_size == 2'b11), 1);
      if (prev_rst && prev_redir) chk("flush_valid", bus_if.inst_valid, 0);
      if (prev_rst && prev_valid && !prev_ready && !prev_redir) begin
        chk("stable_valid", bus_if.inst_valid, 1);
        chk("stable_pc", bus_if.inst_pc, prev_pc);
        chk("stable_data", bus_if.inst_data, prev_data);
      end
      if (bus_if.inst_valid && bus_if.inst_ready && !redirect_valid) begin
        chk("acc_pc", bus_if.inst_pc, exp_pc);
        chk("acc_data", bus_if.inst_data, rom_word(exp_pc));
        chk("acc_after_halt", mdl_halted, 0);
        got_q.push_back(bus_if.inst_pc);
`ifdef FETCH_HALT_ON_EBREAK_EN
        if (rom_word(exp_pc) == EBREAK) mdl_halted = 1'b1;
`endif
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect_valid) begin
        exp_pc     = {redirect_pc[31:2], 2'b00};
        mdl_halted = 1'b0;
      end
    end
    prev_rst   = rst_n;
    prev_valid = bus_if.inst_valid;
    prev_ready = bus_if.inst_ready;
    prev_redir = redirect_valid;
    prev_pc    = bus_if.inst_pc;
    prev_data  = bus_if.inst_data;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_got(input int need, input string tag);
    int k = 0;
    while (got_q.size() < need && k < 30) begin
      tick();
      k++;
    end
    chk(tag, (got_q.size() >= need), 1);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int base;
    int idx;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; rom_ebreak = 1'b0;
    bus_if.bus_gnt = 1'b0; bus_if.inst_ready = 1'b0;
    exp_pc = '0; mdl_halted = 1'b0;
    #1;
    repeat (2) tick();
    chk("rst_size", bus_if.bus_size, 0);
    chk("rst_addr", bus_if.bus_addr, 0);
    chk("rst_valid", bus_if.inst_valid, 0);
    chk("rst_halted", halted, 0);

    // First launch, two-edge latency, one word per cycle
    rst_n = 1'b1; bus_if.bus_gnt = 1'b1; bus_if.inst_ready = 1'b1;
    tick();
    chk("first_size", bus_if.bus_size, 2'b11);
    chk("first_addr", bus_if.bus_addr, 32'h0);
    tick();
    chk("lat_valid0", bus_if.inst_valid, 0);
    tick();
    chk("lat_valid1", bus_if.inst_valid, 1);
    chk("lat_pc0", bus_if.inst_pc, 32'h0);
    chk("lat_data0", bus_if.inst_data, rom_word(32'h0));
    tick();
    chk("seq_pc4", bus_if.inst_pc, 32'h4);
    tick();
    chk("seq_pc8", bus_if.inst_pc, 32'h8);

    // Decode stall: FIFO fills to depth, bus goes idle, then drains exactly the buffered words
    bus_if.inst_ready = 1'b0;
    repeat (10) tick();
    chk("stall_idle", bus_if.bus_size, 2'b00);
    chk("stall_valid", bus_if.inst_valid, 1);
    bus_if.bus_gnt = 1'b0; bus_if.inst_ready = 1'b1;
    base = got_q.size();
    repeat (8) tick();
    chk("stall_drain_n", got_q.size() - base, 4);
    chk("stall_empty", bus_if.inst_valid, 0);

    // Redirect with both slots busy, misaligned target
    bus_if.bus_gnt = 1'b1;
    repeat (4) tick();
    base = got_q.size();
    do_redirect(32'h1E);
    chk("redir_addr", bus_if.bus_addr, 32'h1C);
    chk("redir_size", bus_if.bus_size, 2'b11);
    chk("redir_valid", bus_if.inst_valid, 0);
    wait_got(base + 1, "redir_timeout");
    if (got_q.size() > base) chk("redir_first_pc", got_q[base], 32'h1C);

    // Address wrap
    base = got_q.size();
    do_redirect(32'hFFFF_FFFC);
    chk("wrap_addr0", bus_if.bus_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr1", bus_if.bus_addr, 32'h0);
    chk("wrap_size1", bus_if.bus_size, 2'b11);
    wait_got(base + 2, "wrap_timeout");
    if (got_q.size() > base + 1) begin
      chk("wrap_pc0", got_q[base], 32'hFFFF_FFFC);
      chk("wrap_pc1", got_q[base + 1], 32'h0);
    end

    // Redirect coinciding with a pop
    repeat (3) tick();
    chk("rp_valid_before", bus_if.inst_valid, 1);
    do_redirect(32'h100);
    chk("rp_flushed", bus_if.inst_valid, 0);
    repeat (4) tick();

    // Asynchronous reset mid-burst
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", bus_if.inst_valid, 0);
    chk("mrst_size", bus_if.bus_size, 0);
    chk("mrst_addr", bus_if.bus_addr, 0);
    tick();
    rst_n = 1'b1;
    base = got_q.size();
    wait_got(base + 1, "mrst_timeout");
    if (got_q.size() > base) chk("mrst_first_pc", got_q[base], 32'h0);

    // ebreak at 0x3C
    rom_ebreak = 1'b1;
    base = got_q.size();
    do_redirect(32'h30);
    repeat (20) tick();
    idx = -1;
    for (int i = base; i < got_q.size(); i++) if (got_q[i] == 32'h3C) idx = i;
    chk("ebrk_seen", (idx >= 0), 1);
`ifdef FETCH_HALT_ON_EBREAK_EN
    chk("ebrk_last", got_q.size(), idx + 1);
    chk("ebrk_halted", halted, 1);
    chk("ebrk_idle", bus_if.bus_size, 2'b00);
    chk("ebrk_empty", bus_if.inst_valid, 0);
    do_redirect(32'h200);
    chk("ebrk_unhalt", halted, 0);
`else
    chk("ebrk_next", (idx >= 0 && idx + 1 < got_q.size()) ? got_q[idx + 1] : 32'hDEAD, 32'h40);
    chk("ebrk_no_halt", halted, 0);
    do_redirect(32'h200);
`endif
    tick();
    rom_ebreak = 1'b0;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bus_if.bus_gnt    = ($urandom_range(0, 3) != 0);
      bus_if.inst_ready = ($urandom_range(0, 9) < 7);
      redirect_valid    = ($urandom_range(0, 39) == 0);
      redirect_pc       = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : 32'($urandom);
      rst_n             = ($urandom_range(0, 599) != 0);
      tick();
    end
    rst_n = 1'b1; redirect_valid = 1'b0; bus_if.inst_ready = 1'b1; bus_if.bus_gnt = 1'b1;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
